prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue.sv | 204 ++++++++++++++++++++
 tb/tb_prefetch_queue.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches whole cache lines over a tagged
// request/response bus and streams {instr, pc} pairs from a circular queue.
// Handshakes: the request is presented with bus_reqcyc and held unchanged
// until the cycle bus_reqack is high (the transfer happens on that edge).
// A response beat transfers on the cycle bus_respcyc is high, its tag matches
// REQ_TAG and bus_respack is returned. An output entry transfers on the
// cycle out_valid && out_ready.
module prefetch_queue #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BEATS          = 8,
  parameter int unsigned DEPTH          = 32,
  parameter logic [BUS_TAG_WIDTH-1:0] REQ_TAG = 13'h1100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect,
  input  logic [63:0]               redirect_pc,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic [63:0]               out_pc,
  output logic [$clog2(DEPTH):0]    count,
  output logic [1:0]                dbg_state
);

  localparam int unsigned LINE_BYTES = BEATS * 8;
  localparam int unsigned LINE_SHIFT = $clog2(LINE_BYTES);
  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned CW         = AW + 1;
  localparam int unsigned BW         = $clog2(BEATS) + 1;
  localparam logic [63:0] LINE_MASK  = ~((64'd1 << LINE_SHIFT) - 64'd1);
  localparam logic [63:0] WORD_MASK  = ~64'h3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     fetch_pc_q, fetch_pc_d;
  logic [63:0]     line_base_q, line_base_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            drop_q, drop_d;     // redirect seen while request pending
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     mem_instr_q [DEPTH];
  logic [63:0]     mem_pc_q    [DEPTH];

  logic            beat_hit;
  logic            last_beat;
  logic [63:0]     lo_pc;
  logic [63:0]     hi_pc;
  logic            enq_lo;
  logic            enq_hi;
  logic [CW-1:0]   enq_n;
  logic            deq;
  logic [CW-1:0]   free_slots;
  logic [AW-1:0]   hi_idx;

  // Beat decode, enqueue qualification and dequeue handshake
  always_comb begin
    beat_hit   = bus_respcyc && (bus_resptag == REQ_TAG) &&
                 ((state_q == S_RESP) || (state_q == S_DRAIN));
    last_beat  = (beat_q == BW'(BEATS - 1));
    lo_pc      = line_base_q + (64'(beat_q) << 3);
    hi_pc      = lo_pc + 64'd4;
    // Words before the fetch target in the line are skipped; a redirect
    // makes the whole beat stale.
    enq_lo     = (state_q == S_RESP) && beat_hit && !redirect && (lo_pc >= fetch_pc_q);
    enq_hi     = (state_q == S_RESP) && beat_hit && !redirect && (hi_pc >= fetch_pc_q);
    enq_n      = CW'(enq_lo) + CW'(enq_hi);
    deq        = out_valid && out_ready;
    free_slots = CW'(DEPTH) - count_q;
    hi_idx     = enq_lo ? (tail_q + AW'(1)) : tail_q;
  end

  // Next-state logic for the fetch FSM and queue pointers
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    line_base_d = line_base_q;
    beat_d      = beat_q;
    drop_d      = drop_q;
    head_d      = head_q + AW'(deq);
    tail_d      = tail_q + AW'(enq_n);
    count_d     = count_q + enq_n - CW'(deq);
    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Reserve a full line of space before asking, so enqueue never overflows.
        if (!redirect && (free_slots >= CW'(2 * BEATS))) begin
          state_d     = S_REQ;
          line_base_d = fetch_pc_q & LINE_MASK;
          drop_d      = 1'b0;
        end
      end
      S_REQ: begin
        bus_reqcyc = 1'b1;
        if (redirect) drop_d = 1'b1;
        if (bus_reqack) begin
          beat_d  = '0;
          state_d = (drop_q || redirect) ? S_DRAIN : S_RESP;
        end
      end
      S_RESP: begin
        if (beat_hit) begin
          bus_respack = 1'b1;
          if (last_beat) begin
            beat_d     = '0;
            state_d    = S_IDLE;
            fetch_pc_d = line_base_q + 64'(LINE_BYTES);
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
        // A redirect on the final beat has nothing left to drain.
        if (redirect && !(beat_hit && last_beat)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (beat_hit) begin
          bus_respack = 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect wins over any same-cycle enqueue, dequeue or line advance.
    if (redirect) begin
      fetch_pc_d = redirect_pc & WORD_MASK;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  // Control state registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= entry & WORD_MASK;
      line_base_q <= '0;
      beat_q      <= '0;
      drop_q      <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      line_base_q <= line_base_d;
      beat_q      <= beat_d;
      drop_q      <= drop_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Queue storage writes, low half first
  always_ff @(posedge clk) begin
    if (enq_lo) begin
      mem_instr_q[tail_q] <= bus_resp[31:0];
      mem_pc_q[tail_q]    <= lo_pc;
    end
    if (enq_hi) begin
      mem_instr_q[hi_idx] <= bus_resp[63:32];
      mem_pc_q[hi_idx]    <= hi_pc;
    end
  end

  // Output head entry; zero when empty so nothing stale is visible
  always_comb begin
    out_valid  = (count_q != '0);
    out_instr  = out_valid ? mem_instr_q[head_q] : 32'd0;
    out_pc     = out_valid ? mem_pc_q[head_q] : 64'd0;
    bus_req    = BUS_DATA_WIDTH'(line_base_q);
    bus_reqtag = REQ_TAG;
    count      = count_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

  localparam int unsigned BEATS = 8;
  localparam int unsigned DEPTH = 32;
  localparam logic [12:0] TAG   = 13'h1100;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2, ST_DRAIN = 2'd3;

  logic        clk;
  logic        reset;
  logic [63:0] entry;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [5:0]  count;
  logic [1:0]  dbg_state;

  logic        auto_ack;
  assign bus_reqack = auto_ack & bus_reqcyc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_pc_q[$];
  logic [31:0] got_instr_q[$];
  logic [63:0] req_q[$];
  logic [12:0] reqtag_q[$];

  prefetch_queue dut (
    .clk(clk), .reset(reset), .entry(entry),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .count(count), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction word the bench memory holds at a given address
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  // Monitor: record delivered entries and accepted requests just before each rising edge
  always begin
    @(negedge clk);
    #4;
    if (reset) begin
      if (out_valid && out_ready) begin
        got_pc_q.push_back(out_pc);
        got_instr_q.push_back(out_instr);
      end
      if (bus_reqcyc && bus_reqack) begin
        req_q.push_back(bus_req);
        reqtag_q.push_back(bus_reqtag);
      end
    end
  end

  task automatic do_reset(input logic [63:0] entry_v, input logic ack_en);
    @(negedge clk);
    reset = 1'b0;
    entry = entry_v;
    redirect = 1'b0;
    redirect_pc = '0;
    bus_respcyc = 1'b0;
    bus_resp = '0;
    bus_resptag = '0;
    out_ready = 1'b0;
    auto_ack = ack_en;
    exp_q.delete();
    got_pc_q.delete();
    got_instr_q.delete();
    req_q.delete();
    reqtag_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_req(input int n_prev);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (req_q.size() > n_prev) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_req: no request after 60 cycles, have %0d need %0d", req_q.size(), n_prev + 1);
  endtask

  // Drive beats k0..k1 of line lb back to back; redirect on beat redir_k (-1 = none)
  task automatic serve_beats(input logic [63:0] lb, input int k0, input int k1,
                             input int redir_k, input logic [63:0] rpc);
    for (int k = k0; k <= k1; k++) begin
      @(negedge clk);
      bus_respcyc = 1'b1;
      bus_resptag = TAG;
      bus_resp = {mem_word(lb + 64'(8 * k) + 64'd4), mem_word(lb + 64'(8 * k))};
      redirect = (k == redir_k);
      redirect_pc = rpc;
      #4;
      n_checks++;
      if (bus_respack !== 1'b1) begin
        n_fail++;
        $display("FAIL respack beat %0d: got %b expected 1", k, bus_respack);
      end
    end
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus_respcyc = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    entry = 64'h1000;
    redirect = 1'b0;
    redirect_pc = '0;
    bus_respcyc = 1'b1;
    bus_resp = '0;
    bus_resptag = TAG;
    out_ready = 1'b1;
    auto_ack = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL reset_reqcyc: got %b expected 0", bus_reqcyc); end
    n_checks++; if (bus_respack !== 1'b0) begin n_fail++; $display("FAIL reset_respack: got %b expected 0", bus_respack); end
    n_checks++; if (out_instr !== 32'd0 || out_pc !== 64'd0) begin n_fail++; $display("FAIL reset_out: got instr %h pc %h expected 0 0", out_instr, out_pc); end
  endtask

  task automatic test_basic();
    do_reset(64'h1000, 1'b1);
    out_ready = 1'b1;
    wait_req(0);
    n_checks++; if (req_q[0] !== 64'h1000) begin n_fail++; $display("FAIL basic_req0: got %h expected 1000", req_q[0]); end
    n_checks++; if (reqtag_q[0] !== TAG) begin n_fail++; $display("FAIL basic_reqtag: got %h expected %h", reqtag_q[0], TAG); end
    serve_beats(64'h1000, 0, 7, -1, '0);
    bus_idle();
    wait_req(1);
    n_checks++; if (req_q[1] !== 64'h1040) begin n_fail++; $display("FAIL basic_req1: got %h expected 1040", req_q[1]); end
    repeat (12) @(negedge clk);
    for (int i = 0; i < 16; i++) exp_q.push_back(64'h1000 + 64'(4 * i));
    n_checks++; if (got_pc_q.size() != 16) begin n_fail++; $display("FAIL basic_count: got %0d expected 16", got_pc_q.size()); end
    for (int i = 0; i < 16 && i < got_pc_q.size(); i++) begin
      n_checks++;
      if (got_pc_q[i] !== exp_q[i] || got_instr_q[i] !== mem_word(exp_q[i])) begin
        n_fail++;
        $display("FAIL basic_stream[%0d]: got pc %h instr %h expected pc %h instr %h",
                 i, got_pc_q[i], got_instr_q[i], exp_q[i], mem_word(exp_q[i]));
      end
    end
  endtask

  task automatic test_unaligned();
    do_reset(64'h1018, 1'b1);
    out_ready = 1'b1;
    wait_req(0);
    n_checks++; if (req_q[0] !== 64'h1000) begin n_fail++; $display("FAIL unaligned_req: got %h expected 1000", req_q[0]); end
    serve_beats(64'h1000, 0, 7, -1, '0);
    bus_idle();
    repeat (15) @(negedge clk);
    for (int i = 0; i < 10; i++) exp_q.push_back(64'h1018 + 64'(4 * i));
    n_checks++; if (got_pc_q.size() != 10) begin n_fail++; $display("FAIL unaligned_count: got %0d expected 10", got_pc_q.size()); end
    for (int i = 0; i < 10 && i < got_pc_q.size(); i++) begin
      n_checks++;
      if (got_pc_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL unaligned_stream[%0d]: got pc %h expected %h", i, got_pc_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(64'h1000, 1'b1);
    wait_req(0);
    serve_beats(64'h1000, 0, 7, -1, '0);
    bus_idle();
    wait_req(1);
    n_checks++; if (req_q[1] !== 64'h1040) begin n_fail++; $display("FAIL bp_req1: got %h expected 1040", req_q[1]); end
    serve_beats(64'h1040, 0, 7, -1, '0);
    bus_idle();
    repeat (10) @(negedge clk);
    #4;
    n_checks++; if (count !== 6'd32) begin n_fail++; $display("FAIL bp_full: got %0d expected 32", count); end
    n_checks++; if (req_q.size() != 2 || bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL bp_no_req_full: got %0d reqs reqcyc %b expected 2 0", req_q.size(), bus_reqcyc); end
    @(negedge clk);
    out_ready = 1'b1;
    repeat (15) @(negedge clk);
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    #4;
    n_checks++; if (count !== 6'd17) begin n_fail++; $display("FAIL bp_count17: got %0d expected 17", count); end
    n_checks++; if (req_q.size() != 2) begin n_fail++; $display("FAIL bp_no_req_17: got %0d reqs expected 2", req_q.size()); end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_req(2);
    n_checks++; if (req_q[2] !== 64'h1080) begin n_fail++; $display("FAIL bp_req2: got %h expected 1080", req_q[2]); end
    @(negedge clk);
    out_ready = 1'b1;
    serve_beats(64'h1080, 0, 7, -1, '0);
    bus_idle();
    repeat (40) @(negedge clk);
    for (int i = 0; i < 48; i++) exp_q.push_back(64'h1000 + 64'(4 * i));
    n_checks++; if (got_pc_q.size() != 48) begin n_fail++; $display("FAIL bp_total: got %0d expected 48", got_pc_q.size()); end
    for (int i = 0; i < 48 && i < got_pc_q.size(); i++) begin
      n_checks++;
      if (got_pc_q[i] !== exp_q[i] || got_instr_q[i] !== mem_word(exp_q[i])) begin
        n_fail++;
        $display("FAIL bp_stream[%0d]: got pc %h instr %h expected pc %h", i, got_pc_q[i], got_instr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(64'h1000, 1'b1);
    out_ready = 1'b1;
    wait_req(0);
    serve_beats(64'h1000, 0, 7, 3, 64'h2004);
    bus_idle();
    #4;
    n_checks++; if (count !== 6'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got count %0d valid %b expected 0 0", count, out_valid); end
    n_checks++; if (got_pc_q.size() != 3) begin n_fail++; $display("FAIL redir_delivered: got %0d expected 3", got_pc_q.size()); end
    wait_req(1);
    n_checks++; if (req_q[1] !== 64'h2000) begin n_fail++; $display("FAIL redir_req: got %h expected 2000", req_q[1]); end
    serve_beats(64'h2000, 0, 7, -1, '0);
    bus_idle();
    repeat (20) @(negedge clk);
    exp_q.push_back(64'h1000);
    exp_q.push_back(64'h1004);
    exp_q.push_back(64'h1008);
    for (int i = 0; i < 15; i++) exp_q.push_back(64'h2004 + 64'(4 * i));
    n_checks++; if (got_pc_q.size() != 18) begin n_fail++; $display("FAIL redir_total: got %0d expected 18", got_pc_q.size()); end
    for (int i = 0; i < 18 && i < got_pc_q.size(); i++) begin
      n_checks++;
      if (got_pc_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL redir_stream[%0d]: got pc %h expected %h", i, got_pc_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_foreign_tag();
    do_reset(64'h1000, 1'b1);
    wait_req(0);
    serve_beats(64'h1000, 0, 3, -1, '0);
    @(negedge clk);
    bus_respcyc = 1'b1;
    bus_resptag = 13'h0AAA;
    bus_resp = 64'hDEAD_BEEF_DEAD_BEEF;
    #4;
    n_checks++; if (bus_respack !== 1'b0) begin n_fail++; $display("FAIL foreign_ack: got %b expected 0", bus_respack); end
    @(negedge clk);
    bus_respcyc = 1'b0;
    #4;
    n_checks++; if (count !== 6'd8 || dbg_state !== ST_RESP) begin n_fail++; $display("FAIL foreign_queue: got count %0d state %0d expected 8 2", count, dbg_state); end
    serve_beats(64'h1000, 4, 7, -1, '0);
    bus_idle();
    #4;
    n_checks++; if (count !== 6'd16) begin n_fail++; $display("FAIL foreign_final: got %0d expected 16", count); end
    n_checks++; if (out_pc !== 64'h1000 || out_instr !== mem_word(64'h1000)) begin n_fail++; $display("FAIL foreign_head: got pc %h instr %h expected 1000 %h", out_pc, out_instr, mem_word(64'h1000)); end
  endtask

  task automatic test_req_hold();
    do_reset(64'h1000, 1'b0);
    repeat (2) @(negedge clk);
    #4;
    n_checks++; if (bus_reqcyc !== 1'b1 || bus_req !== 64'h1000 || dbg_state !== ST_REQ) begin n_fail++; $display("FAIL hold_req: got cyc %b addr %h state %0d expected 1 1000 1", bus_reqcyc, bus_req, dbg_state); end
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 64'h4000;
    @(negedge clk);
    redirect = 1'b0;
    auto_ack = 1'b1;
    #4;
    n_checks++; if (bus_reqcyc !== 1'b1 || bus_req !== 64'h1000) begin n_fail++; $display("FAIL hold_stable: got cyc %b addr %h expected 1 1000", bus_reqcyc, bus_req); end
    wait_req(0);
    n_checks++; if (dbg_state !== ST_DRAIN) begin n_fail++; $display("FAIL hold_drain: got %0d expected 3", dbg_state); end
    serve_beats(64'h1000, 0, 7, 2, 64'h500A);
    bus_idle();
    #4;
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL hold_drained: got %0d expected 0", count); end
    wait_req(1);
    n_checks++; if (req_q[1] !== 64'h5000) begin n_fail++; $display("FAIL hold_req2: got %h expected 5000", req_q[1]); end
    serve_beats(64'h5000, 0, 7, -1, '0);
    bus_idle();
    #4;
    n_checks++; if (count !== 6'd14 || out_pc !== 64'h5008) begin n_fail++; $display("FAIL hold_result: got count %0d pc %h expected 14 5008", count, out_pc); end
  endtask

  task automatic test_reset_mid();
    int n_prev;
    do_reset(64'h1000, 1'b1);
    wait_req(0);
    serve_beats(64'h1000, 0, 4, -1, '0);
    @(negedge clk);
    bus_respcyc = 1'b1;
    bus_resptag = TAG;
    bus_resp = {mem_word(64'h102C), mem_word(64'h1028)};
    #2;
    reset = 1'b0;
    entry = 64'h3040;
    #1;
    n_checks++; if (dbg_state !== ST_IDLE || count !== 6'd0) begin n_fail++; $display("FAIL rmid_state: got state %0d count %0d expected 0 0", dbg_state, count); end
    n_checks++; if (out_valid !== 1'b0 || out_pc !== 64'd0 || out_instr !== 32'd0) begin n_fail++; $display("FAIL rmid_out: got valid %b pc %h instr %h expected 0", out_valid, out_pc, out_instr); end
    n_checks++; if (bus_reqcyc !== 1'b0 || bus_respack !== 1'b0) begin n_fail++; $display("FAIL rmid_bus: got reqcyc %b respack %b expected 0 0", bus_reqcyc, bus_respack); end
    bus_idle();
    n_prev = req_q.size();
    @(negedge clk);
    reset = 1'b1;
    wait_req(n_prev);
    n_checks++; if (req_q[n_prev] !== 64'h3040) begin n_fail++; $display("FAIL rmid_req: got %h expected 3040", req_q[n_prev]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unaligned();
    test_backpressure();
    test_redirect();
    test_foreign_tag();
    test_req_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
